// File: rtl/stdp_pkg.sv
// Shared types and helpers for the STDP column: FSM states, spike-time decode, saturating weight math.
// Pure declarations, no timing and no backpressure.
package stdp_pkg;

  typedef enum logic [1:0] {IDLE, TEST, LEARN, DONE} state_t;

  localparam int MAXW = 16;

  // A spike-time field carries "no spike" as a set bit just above the time bits.
  function automatic logic no_spike(input logic [MAXW-1:0] tv, input int tbits);
    logic [MAXW-1:0] sh;
    sh = tv >> tbits;
    return sh[0];
  endfunction

  function automatic logic [MAXW-1:0] sat_inc(input logic [MAXW-1:0] w, input logic [MAXW-1:0] wmax);
    return (w >= wmax) ? wmax : w + MAXW'(1);
  endfunction

  function automatic logic [MAXW-1:0] sat_dec(input logic [MAXW-1:0] w);
    return (w == '0) ? '0 : w - MAXW'(1);
  endfunction

endpackage

// File: rtl/stdp_neuron.sv
// Integrate-and-fire neuron: sums weights of active inputs each enabled cycle; fire_now is combinational.
// Potential freezes once fired; cleared by clr. No backpressure.
module stdp_neuron #(
  parameter int N_IN   = 16,
  parameter int WBITS  = 3,
  parameter int THRESH = 8,
  parameter int PBITS  = 10
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  clr,
  input  logic                  en,
  input  logic [N_IN-1:0]       active,
  input  logic [N_IN*WBITS-1:0] w_row,
  output logic                  fire_now,
  output logic                  fired
);

  logic [PBITS-1:0] pot;
  logic [PBITS-1:0] sum;
  logic [PBITS-1:0] pot_nxt;

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (active[i]) sum = sum + PBITS'(w_row[i*WBITS +: WBITS]);
    end
    pot_nxt  = pot + sum;
    fire_now = en && !fired && (pot_nxt >= PBITS'(THRESH));
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pot   <= '0;
      fired <= 1'b0;
    end else if (clr) begin
      pot   <= '0;
      fired <= 1'b0;
    end else if (en && !fired) begin
      pot <= pot_nxt;
      if (fire_now) fired <= 1'b1;
    end
  end

endmodule

// File: rtl/stdp_column.sv
// Temporal-coding column: self-timed TEST pass over T_TEST cycles, 1-WTA, optional per-synapse STDP pass.
// done T_TEST+1 (or T_TEST+N_IN+1 when training) cycles after start; start ignored while busy.
module stdp_column
  import stdp_pkg::*;
#(
  parameter int N_IN   = 16,
  parameter int N_NEUR = 8,
  parameter int WBITS  = 3,
  parameter int TBITS  = 3,
  parameter int THRESH = 8,
  parameter int INIT_W = 1,
  parameter int RULE   = 1
) (
  input  logic                        clk,
  input  logic                        rst_l,
  input  logic                        start,
  input  logic                        train,
  input  logic [N_IN*(TBITS+1)-1:0]   in_times,
  output logic                        busy,
  output logic                        done,
  output logic [TBITS:0]              out_time,
  output logic [$clog2(N_NEUR)-1:0]   winner,
  input  logic [$clog2(N_NEUR)-1:0]   rd_neur,
  input  logic [$clog2(N_IN)-1:0]     rd_syn,
  output logic [WBITS-1:0]            rd_w
);

  localparam int WMAX   = 2**WBITS - 1;
  localparam int T_TEST = 2**TBITS;
  localparam int TW     = TBITS + 1;
  localparam int PBITS  = $clog2(N_IN*WMAX*T_TEST + 1);
  localparam int NB     = $clog2(N_NEUR);
  localparam int SB     = $clog2(N_IN);
  localparam int CBITS  = ((TBITS > SB) ? TBITS : SB) + 1;

  state_t               state, nxt;
  logic [CBITS-1:0]     cnt;
  logic [N_IN*TW-1:0]   times_q;
  logic                 train_q;
  logic                 accept, test_en, learn_en;
  logic [N_IN-1:0]      active;
  logic [N_NEUR-1:0]    fire_now, fired;
  logic                 any_fire;
  logic [NB-1:0]        first_idx;
  logic [WBITS-1:0]     w [N_NEUR][N_IN];
  logic [N_IN*WBITS-1:0] w_rows [N_NEUR];
  logic [WBITS-1:0]     w_new [N_NEUR];
  logic [SB-1:0]        s;
  logic [TW-1:0]        ts;
  logic                 x, early, has_win;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = TEST;
      TEST:    if (cnt == CBITS'(T_TEST-1)) nxt = train_q ? LEARN : DONE;
      LEARN:   if (cnt == CBITS'(N_IN-1)) nxt = DONE;
      DONE:    nxt = start ? TEST : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == TEST) || (state == LEARN);
    done     = (state == DONE);
    accept   = start && ((state == IDLE) || (state == DONE));
    test_en  = (state == TEST);
    learn_en = (state == LEARN);
  end

  // One counter serves as t during TEST and as the synapse index during LEARN.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt     <= '0;
      times_q <= '0;
      train_q <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      times_q <= in_times;
      train_q <= train;
    end else if (test_en && cnt == CBITS'(T_TEST-1)) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt + CBITS'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      active[i] = !no_spike(MAXW'(times_q[i*TW +: TW]), TBITS) &&
                  (times_q[i*TW +: TBITS] <= cnt[TBITS-1:0]);
    end
    for (int j = 0; j < N_NEUR; j++) begin
      for (int i = 0; i < N_IN; i++) w_rows[j][i*WBITS +: WBITS] = w[j][i];
    end
  end

  for (genvar j = 0; j < N_NEUR; j++) begin : g_neur
    stdp_neuron #(.N_IN(N_IN), .WBITS(WBITS), .THRESH(THRESH), .PBITS(PBITS)) u_neur (
      .clk      (clk),
      .rst_l    (rst_l),
      .clr      (accept),
      .en       (test_en),
      .active   (active),
      .w_row    (w_rows[j]),
      .fire_now (fire_now[j]),
      .fired    (fired[j])
    );
  end

  always_comb begin
    any_fire  = 1'b0;
    first_idx = '0;
    for (int j = N_NEUR-1; j >= 0; j--) begin
      if (fire_now[j]) begin
        any_fire  = 1'b1;
        first_idx = NB'(j);
      end
    end
  end

  // Only the first firing cycle captures the winner; out_time MSB doubles as "no winner yet".
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      out_time <= {1'b1, {TBITS{1'b0}}};
      winner   <= '0;
    end else if (accept) begin
      out_time <= {1'b1, {TBITS{1'b0}}};
      winner   <= '0;
    end else if (test_en && any_fire && out_time[TBITS]) begin
      out_time <= {1'b0, cnt[TBITS-1:0]};
      winner   <= first_idx;
    end
  end

  assign s       = cnt[SB-1:0];
  assign has_win = !out_time[TBITS];

  always_comb begin
    ts = '1;
    for (int i = 0; i < N_IN; i++) begin
      if (SB'(i) == s) ts = times_q[i*TW +: TW];
    end
    x     = !no_spike(MAXW'(ts), TBITS);
    early = (ts[TBITS-1:0] <= out_time[TBITS-1:0]);
    for (int j = 0; j < N_NEUR; j++) begin
      w_new[j] = w[j][s];
      if (has_win && (NB'(j) == winner)) begin
        if (RULE == 1) w_new[j] = (x && early) ? WBITS'(sat_inc(MAXW'(w[j][s]), MAXW'(WMAX)))
                                               : WBITS'(sat_dec(MAXW'(w[j][s])));
        else           w_new[j] = x ? WBITS'(WMAX) : '0;
      end else if (fired[j]) begin
        if (x) w_new[j] = (RULE == 1) ? WBITS'(sat_dec(MAXW'(w[j][s]))) : '0;
      end else if (x) begin
        w_new[j] = WBITS'(sat_inc(MAXW'(w[j][s]), MAXW'(WMAX)));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int j = 0; j < N_NEUR; j++)
        for (int i = 0; i < N_IN; i++) w[j][i] <= WBITS'(INIT_W);
    end else if (learn_en) begin
      for (int j = 0; j < N_NEUR; j++) w[j][s] <= w_new[j];
    end
  end

  assign rd_w = w[rd_neur][rd_syn];

endmodule

// File: doc/stdp_column.md
# stdp_column

Parametrised temporal-coding column: N_IN input spike times are applied to N_NEUR integrate-and-fire neurons over a self-timed gamma cycle, 1-WTA selects the earliest-firing neuron, and an optional per-synapse STDP pass updates the weights. It is the successor of the fixed-size clocked STDP layer. It owns its own cycle counter and start/done handshake instead of consuming an external time value, and it supports selectable binary or incremental learning.

## Interface
- N_IN, 16, number of input synapses per neuron
- N_NEUR, 8, number of neurons
- WBITS, 3, weight width; WMAX = 2**WBITS-1
- TBITS, 3, spike-time width; T_TEST = 2**TBITS cycles
- THRESH, 8, firing threshold on body potential
- INIT_W, 1, weight value after reset
- RULE, 1, 0 = binary STDP, 1 = incremental ±1 saturating STDP
- clk  in  1  clock
- rst_l  in  1  reset; asynchronous, active-low
- start  in  1  begin a gamma cycle; accepted only when busy=0
- train  in  1  sampled with start; 1 = run the LEARN phase
- in_times  in  N_IN×(TBITS+1)  per input: MSB=1 means no spike; otherwise bits [TBITS-1:0] give the spike time
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at the end of a gamma cycle
- out_time  out  TBITS+1  winner firing time; MSB=1 means no neuron fired
- winner  out  $clog2(N_NEUR)  winning neuron index; 0 when none fired
- rd_neur, rd_syn  in  index widths  weight readback address
- rd_w  out  WBITS  weights[rd_neur][rd_syn], combinational from registers

## Operation
- FSM states: IDLE, TEST, LEARN, DONE.
  - IDLE→TEST on start: latch in_times and train; clear potentials, fired flags, out_time (to MSB=1) and winner.
  - TEST runs t = 0..T_TEST-1. Then go to LEARN if train=1, else to DONE.
  - LEARN runs s = 0..N_IN-1, then goes to DONE.
  - DONE asserts done and returns to IDLE.
- Input i is active at cycle t when its MSB=0 and its time ≤ t. This is a ramp response.
- Each cycle, every unfired neuron j adds Σ weights[j][i] over active inputs to its potential.
- A neuron fires at t when its new potential ≥ THRESH. Its potential then freezes and its fired flag is set.
- 1-WTA: the first t with any firing sets out_time = t and winner = the lowest firing index. Later firings set fired flags only.
- Potential width must hold N_IN·WMAX·T_TEST without overflow.
- In LEARN cycle s, synapse s of every neuron j is updated in parallel. Let x = "input s spiked" (MSB=0).
  - Winner j (only if a winner exists):
    - RULE=1: x and time ≤ out_time → +1; otherwise −1.
    - RULE=0: x → WMAX; otherwise 0.
  - Fired non-winner: x → −1 (RULE=1) or 0 (RULE=0); no change otherwise.
  - Unfired neuron: x → +1 in both modes; no change otherwise.
  - All updates saturate at 0 and at WMAX.
- start while busy=1 is ignored. train=0 leaves weights untouched.

## Timing
- Reset values:
  - busy=0, done=0, out_time = {1, 0…}, winner=0.
  - All weights = INIT_W; FSM in IDLE.
- Cycle numbering: start is sampled at edge 0.
  - TEST occupies cycles 1..T_TEST.
  - train=0: done is high in cycle T_TEST+1.
  - train=1: LEARN occupies cycles T_TEST+1..T_TEST+N_IN, and done is high in cycle T_TEST+N_IN+1.
- busy falls in the same cycle that done pulses. The next start is accepted in that cycle.
- out_time and winner are final from the cycle after the first firing and hold until the next accepted start.
- Weight updates become visible on rd_w the cycle after their LEARN cycle.
- rst_l asserted mid-cycle returns the block to IDLE immediately, restores INIT_W, and produces no done pulse.

## Structure
- Shared package stdp_pkg holds:
  - the state enum;
  - the NO_SPIKE encoding helper;
  - the saturating add/sub functions on WBITS.
- One sub-module, stdp_neuron: potential accumulator, threshold compare and fired flag, instantiated N_NEUR times.
- WTA arbitration, the FSM and the weight array live in the top level.

## Test plan
- Reset with defaults:
  - Required: out_time=4'b1000, winner=0, busy=0, and rd_w=1 for all addresses.
- train=0, all 16 inputs at t=0:
  - Required: every neuron sees potential 16 at t=0; out_time=0, winner=0; done exactly 9 cycles after start; weights unchanged.
- Same stimulus, train=1, RULE=1:
  - Required: neuron 0 weights = 2; neurons 1..7 weights = 0; done 25 cycles after start.
- train=1, inputs 0..3 at t=7, rest no-spike:
  - Required: potential 4 < 8, so no firing; out_time MSB=1.
  - Required: synapses 0..3 of all neurons = 2; synapses 4..15 unchanged at 1.
- Repeat the capture scenario 10 times:
  - Required: winner weights saturate at 7 and never wrap.
  - Required with RULE=0: winner weights = 7 after one pass.
- Concurrency and reset:
  - start pulsed during TEST is ignored and the gamma cycle timing is unchanged.
  - rst_l asserted during LEARN: no done pulse, and all weights read 1.
